// File: rtl/mvp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mvp_arbiter
//  Description : Two-requester front end for a single shared matrix-vector
//                product engine. Grants one requester at a time, latches its
//                operands, runs one engine transaction and returns the result
//                to the owner. Arbitration alternates when both requesters
//                are asking at the same time.
//  Revision    : 1.0 - initial release
// ============================================================================
module mvp_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_i_valid,
  output logic [1:0]             req_i_ready,
  input  logic [2*16*WIDTH-1:0]  req_matrix,
  input  logic [2*4*WIDTH-1:0]   req_vector,
  output logic [1:0]             req_o_valid,
  input  logic [1:0]             req_o_ready,
  output logic [4*WIDTH-1:0]     req_product,
  output logic                   eng_i_valid,
  input  logic                   eng_i_ready,
  output logic [16*WIDTH-1:0]    eng_matrix,
  output logic [4*WIDTH-1:0]     eng_vector,
  input  logic [4*WIDTH-1:0]     eng_product,
  input  logic                   eng_o_valid,
  output logic                   eng_o_ready,
  output logic                   owner,
  output logic                   busy,
  output logic [15:0]            ops_done
);

  localparam int MAT_W = 16 * WIDTH;
  localparam int VEC_W = 4 * WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RETURN = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               last_grant;
  logic               grant;
  logic               accept;
  logic               capture;
  logic               ret_done;
  logic [MAT_W-1:0]   op_matrix;
  logic [VEC_W-1:0]   op_vector;
  logic [VEC_W-1:0]   result;

  // Pick the requester to serve: the only one asking, or the one that was
  // not served last when both ask together.
  always_comb begin
    grant = 1'b0;
    case (req_i_valid)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

  // Next-state logic and all handshake outputs, decoded from the current state.
  always_comb begin
    state_nxt   = state;
    req_i_ready = 2'b00;
    req_o_valid = 2'b00;
    eng_i_valid = 1'b0;
    eng_o_ready = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    ret_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_i_valid != 2'b00) begin
          req_i_ready = 2'b01 << grant;
          accept      = 1'b1;
          state_nxt   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        eng_i_valid = 1'b1;
        if (eng_i_ready) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        eng_o_ready = 1'b1;
        if (eng_o_valid) begin
          capture   = 1'b1;
          state_nxt = ST_RETURN;
        end
      end
      ST_RETURN: begin
        req_o_valid = 2'b01 << owner;
        if (req_o_ready[owner]) begin
          ret_done  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand/result capture, owner tracking, fairness memory and completion count.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      op_matrix  <= '0;
      op_vector  <= '0;
      result     <= '0;
      ops_done   <= 16'd0;
    end else begin
      if (accept) begin
        owner     <= grant;
        op_matrix <= grant ? req_matrix[2*MAT_W-1:MAT_W] : req_matrix[MAT_W-1:0];
        op_vector <= grant ? req_vector[2*VEC_W-1:VEC_W] : req_vector[VEC_W-1:0];
      end
      if (capture) begin
        result <= eng_product;
      end
      if (ret_done) begin
        last_grant <= owner;
      end
      // Written every cycle so the counter naturally wraps at 16'hFFFF.
      ops_done <= ops_done + {15'd0, ret_done};
    end
  end

  assign eng_matrix  = op_matrix;
  assign eng_vector  = op_vector;
  assign req_product = result;
  assign busy        = (state != ST_IDLE);

endmodule
`default_nettype wire
